// File: rtl/perft_report_sink.sv
// Consumer end of the perft result stream: forwards per-root-move lines, then emits
// total-node and elapsed-cycle summary lines for the host formatter.
module perft_report_sink #(
    parameter int MOVE_W = 16,
    parameter int NODE_W = 48,
    parameter int CYC_W  = 48,
    parameter int ROOT_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MOVE_W-1:0] in_move,
    input  logic [NODE_W-1:0] in_nodes,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_kind,
    output logic [MOVE_W-1:0] out_move,
    output logic [NODE_W-1:0] out_data,
    output logic [ROOT_W-1:0] root_count,
    output logic              overflow,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, COLLECT, EMIT_TOT, EMIT_CYC, DONE} state_t;

    state_t            state;
    logic [NODE_W-1:0] total;
    logic [CYC_W-1:0]  cycles;
    logic              last_seen;
    logic [NODE_W:0]   sum;
    logic [NODE_W-1:0] cyc_data;
    logic              in_hs;
    logic              out_hs;

    // Single output register; a new record may enter in the same cycle the old line leaves.
    assign in_ready = (state == COLLECT) && !last_seen && (!out_valid || out_ready);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign sum      = {1'b0, total} + {1'b0, in_nodes};
    assign busy     = (state == COLLECT) || (state == EMIT_TOT) || (state == EMIT_CYC);
    assign done     = (state == DONE);

    generate
        if (CYC_W >= NODE_W) begin : g_cyc_trunc
            assign cyc_data = cycles[NODE_W-1:0];
        end else begin : g_cyc_ext
            assign cyc_data = {{(NODE_W-CYC_W){1'b0}}, cycles};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            total      <= '0;
            cycles     <= '0;
            last_seen  <= 1'b0;
            root_count <= '0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            out_kind   <= '0;
            out_move   <= '0;
            out_data   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= COLLECT;
                        total      <= '0;
                        cycles     <= '0;
                        last_seen  <= 1'b0;
                        root_count <= '0;
                        overflow   <= 1'b0;
                        out_valid  <= 1'b0;
                        out_kind   <= '0;
                        out_move   <= '0;
                        out_data   <= '0;
                    end
                end
                COLLECT: begin
                    // Cycle count freezes once the final record has been accepted.
                    if (!last_seen) begin
                        if (&cycles) overflow <= 1'b1;
                        else         cycles   <= cycles + CYC_W'(1);
                    end
                    if (in_hs) begin
                        out_valid <= 1'b1;
                        out_kind  <= 2'd0;
                        out_move  <= in_move;
                        out_data  <= in_nodes;
                        if (sum[NODE_W]) begin
                            total    <= '1;
                            overflow <= 1'b1;
                        end else begin
                            total <= sum[NODE_W-1:0];
                        end
                        if (!(&root_count)) root_count <= root_count + ROOT_W'(1);
                        if (in_last) last_seen <= 1'b1;
                    end else if (out_hs) begin
                        if (last_seen) begin
                            out_kind <= 2'd1;
                            out_move <= '0;
                            out_data <= total;
                            state    <= EMIT_TOT;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                EMIT_TOT: begin
                    if (out_ready) begin
                        out_kind <= 2'd2;
                        out_data <= cyc_data;
                        state    <= EMIT_CYC;
                    end
                end
                EMIT_CYC: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
